fifo_buffer: RTL and testbench

- Parametrised synchronous FIFO buffer; successor to the single-bit combinational buffer.
- Stores up to DEPTH words of WIDTH bits and returns them in first-in/first-out order with a registered read port.
- Provides full/empty status and sticky overflow/underflow error flags.
- Used as the generic storage/decoupling element between producer and consumer blocks in the course datapath designs.

---
 rtl/fifo_buffer.sv | 153 +++++++++++++++
 tb/tb_fifo_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_buffer.sv
// -----------------------------------------------------------------------------
// fifo_buffer
//
// Parametrised synchronous FIFO with a registered read port. Up to DEPTH words
// of WIDTH bits are held and returned in first-in/first-out order. Full and
// empty are decoded from an occupancy register. Sticky overflow and underflow
// flags record any push attempted while full or pop attempted while empty.
//
// Parameters:
//   WIDTH   data word width in bits (>= 1)
//   DEPTH   number of entries (power of 2, >= 2)
//   ADDR_W  pointer width, derived from DEPTH (not meant to be overridden)
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high reset; has priority over wr_en/rd_en
//   din         write data
//   wr_en       push request (accepted only when not full)
//   rd_en       pop request (accepted only when not empty)
//   dout        registered read data; holds its value between pops
//   dout_valid  one-cycle pulse when dout carries a newly popped word
//   full        occupancy == DEPTH
//   empty       occupancy == 0
//   count       occupancy (only when FIFO_BUFFER_COUNT_EN is defined)
//   overflow    sticky: push attempted while full
//   underflow   sticky: pop attempted while empty
//
// Build option:
//   FIFO_BUFFER_COUNT_EN  when defined, exposes the occupancy register on the
//                         count output port. When undefined the port is absent
//                         and occupancy stays internal.
// -----------------------------------------------------------------------------
module fifo_buffer #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
`ifdef FIFO_BUFFER_COUNT_EN
    output logic [ADDR_W:0]   count,
`endif
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]   OCC_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   OCC_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    // Storage: no reset so the array maps onto block/distributed RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   occ_reg,    occ_next;
    logic [WIDTH-1:0]  dout_reg,   dout_next;
    logic              valid_reg,  valid_next;
    logic              ovf_reg,    ovf_next;
    logic              unf_reg,    unf_next;

    logic push_ok;
    logic pop_ok;

    // Status is decoded from the registered occupancy, so it reflects the
    // state before the coming edge. This is what makes a simultaneous
    // push+pop on a full FIFO reject the push (and on an empty one the pop).
    assign full  = (occ_reg == OCC_FULL);
    assign empty = (occ_reg == '0);

    assign push_ok = wr_en & ~full;
    assign pop_ok  = rd_en & ~empty;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        occ_next    = occ_reg;
        dout_next   = dout_reg;
        valid_next  = 1'b0;
        ovf_next    = ovf_reg | (wr_en & full);
        unf_next    = unf_reg | (rd_en & empty);

        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end

        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
            dout_next   = mem[rd_ptr_reg];
            valid_next  = 1'b1;
        end

        // Simultaneous accepted push and pop leave occupancy unchanged.
        unique case ({push_ok, pop_ok})
            2'b10:   occ_next = occ_reg + OCC_ONE;
            2'b01:   occ_next = occ_reg - OCC_ONE;
            default: occ_next = occ_reg;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            dout_reg   <= '0;
            valid_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            occ_reg    <= occ_next;
            dout_reg   <= dout_next;
            valid_reg  <= valid_next;
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
        end
    end

    // -------------------------------------------------------------------------
    // Storage write port. Writes are suppressed during reset so that a push
    // coinciding with reset leaves no trace, matching the rejected-op rule.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = valid_reg;
    assign overflow   = ovf_reg;
    assign underflow  = unf_reg;

`ifdef FIFO_BUFFER_COUNT_EN
    assign count = occ_reg;
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// -----------------------------------------------------------------------------
// tb_fifo_buffer
//
// Self-checking bench for fifo_buffer (WIDTH=8, DEPTH=4). A queue-based
// reference model tracks stored words; every accepted pop pushes the expected
// word onto a scoreboard queue, which is popped and compared whenever the DUT
// raises dout_valid. All status outputs are compared every cycle.
// -----------------------------------------------------------------------------
module tb_fifo_buffer;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  din;
    logic              wr_en;
    logic              rd_en;
    logic [WIDTH-1:0]  dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;
`ifdef FIFO_BUFFER_COUNT_EN
    logic [ADDR_W:0]   count;
`endif

    fifo_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
`ifdef FIFO_BUFFER_COUNT_EN
        .count      (count),
`endif
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] sb_q    [$];
    int               model_occ;
    logic [WIDTH-1:0] exp_dout;
    logic             exp_valid;
    logic             exp_ovf;
    logic             exp_unf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Drive one clock of stimulus, advance the model, then compare outputs.
    task automatic cycle(input logic rst, input logic wr, input logic rd, input logic [WIDTH-1:0] d);
        logic m_full;
        logic m_empty;
        logic push_ok;
        logic pop_ok;
        reset = rst;
        wr_en = wr;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_q.delete();
            sb_q.delete();
            exp_dout  = '0;
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
        end else begin
            m_full  = (model_q.size() == DEPTH);
            m_empty = (model_q.size() == 0);
            push_ok = wr && !m_full;
            pop_ok  = rd && !m_empty;
            if (wr && m_full)  exp_ovf = 1'b1;
            if (rd && m_empty) exp_unf = 1'b1;
            exp_valid = pop_ok;
            if (pop_ok) begin
                exp_dout = model_q.pop_front();
                sb_q.push_back(exp_dout);
            end
            if (push_ok) model_q.push_back(d);
        end
        model_occ = model_q.size();
        #1;
        $display("cyc=%0d rst=%0b wr=%0b rd=%0b din=%02h | dout=%02h v=%0b full=%0b empty=%0b ovf=%0b unf=%0b occ=%0d",
                 cyc, rst, wr, rd, d, dout, dout_valid, full, empty, overflow, underflow, model_occ);
        check_eq("dout_valid", dout_valid, exp_valid);
        check_eq("dout",       dout,       exp_dout);
        check_eq("full",       full,       model_occ == DEPTH);
        check_eq("empty",      empty,      model_occ == 0);
        check_eq("overflow",   overflow,   exp_ovf);
        check_eq("underflow",  underflow,  exp_unf);
`ifdef FIFO_BUFFER_COUNT_EN
        check_eq("count",      count,      model_occ);
`endif
        if (dout_valid) begin
            check_eq("sb_has_entry", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) check_eq("sb_dout", dout, sb_q.pop_front());
        end
    endtask

    initial begin
        model_occ = 0;
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;

        // Reset, then idle
        cycle(1, 0, 0, 8'h00);
        cycle(1, 0, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        check_eq("reset_empty", empty, 1);
        check_eq("reset_dout", dout, 8'h00);

        // Fill with A1..A4
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'hA1 + 8'(i));
        check_eq("full_after_4", full, 1);

        // Push while full: rejected, overflow set
        cycle(0, 1, 0, 8'hFF);
        check_eq("ovf_set", overflow, 1);

        // Drain: A1..A4 with single-cycle valid pulses
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 8'h00);
            check_eq("drain_word", dout, 8'hA1 + 8'(i));
        end
        cycle(0, 0, 0, 8'h00);
        check_eq("drain_empty", empty, 1);

        // Pop while empty: rejected, underflow set, dout held
        cycle(0, 0, 1, 8'h00);
        check_eq("unf_no_valid", dout_valid, 0);
        check_eq("unf_dout_held", dout, 8'hA4);
        cycle(0, 0, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        check_eq("flags_sticky", {overflow, underflow}, 2'b11);
        cycle(1, 0, 0, 8'h00);
        check_eq("flags_cleared", {overflow, underflow}, 2'b00);

        // Occupancy 2, then 6 simultaneous push/pop cycles (pointers wrap)
        cycle(0, 1, 0, 8'h20);
        cycle(0, 1, 0, 8'h21);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 8'h10 + 8'(i));
        check_eq("steady_not_full", full, 0);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 1, 8'h00);
        check_eq("steady_last", dout, 8'h15);
        cycle(0, 0, 0, 8'h00);

        // Simultaneous push+pop on full and on empty
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'h30 + 8'(i));
        cycle(0, 1, 1, 8'h3F);
        check_eq("full_both_ovf", overflow, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h00);
        cycle(0, 1, 1, 8'h40);
        check_eq("empty_both_unf", underflow, 1);
        cycle(0, 0, 1, 8'h00);
        cycle(1, 0, 0, 8'h00);

        // Reset mid-operation with wr/rd asserted, valid pulse in flight
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h50 + 8'(i));
        cycle(0, 0, 1, 8'h00);
        cycle(1, 1, 1, 8'h77);
        check_eq("rst_mid_empty", empty, 1);
        check_eq("rst_mid_valid", dout_valid, 0);
        check_eq("rst_mid_dout", dout, 8'h00);
        cycle(0, 1, 0, 8'h55);
        cycle(0, 0, 1, 8'h00);
        check_eq("fresh_word", dout, 8'h55);
        cycle(0, 0, 1, 8'h00);
        check_eq("fresh_only", dout_valid, 0);

        // Random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Final drain
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 1, 8'h00);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
